// File: rtl/decode_mod.sv
// decode_mod: RV32I decode stage with register file and D/E register.
// Optional DECODE_WB_BYPASS_EN: same-cycle write-through of W results.
module decode_mod #(
    parameter int REG_COUNT = 32,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            FlushE,
    input  logic [31:0]     instrD,
    input  logic [31:0]     PCD,
    input  logic [31:0]     PCplus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [31:0]     ImmExtE,
    output logic [4:0]      RdE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [31:0]     PCE,
    output logic [31:0]     PCplus4E,
    output logic            IllegalE
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [XLEN-1:0] rf [REG_COUNT];

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;

    logic       reg_write, mem_write, jump, branch, alu_src, illegal;
    logic [1:0] result_src;
    logic [2:0] alu_ctrl;
    logic [2:0] alu_op;
    logic       alu_bad;
    logic [31:0] imm;
    logic [XLEN-1:0] rd1, rd2;

    assign opcode = instrD[6:0];
    assign funct3 = instrD[14:12];
    assign rs1    = instrD[19:15];
    assign rs2    = instrD[24:20];
    assign rd     = instrD[11:7];

    // ALU operation from funct3; sub only for R-type with funct7[5]
    always_comb begin
        alu_op  = 3'b000;
        alu_bad = 1'b0;
        unique case (1'b1)
            (funct3 == 3'b000):
                alu_op = (opcode == OP_R && instrD[30]) ? 3'b001 : 3'b000;
            (funct3 == 3'b010): alu_op = 3'b101;
            (funct3 == 3'b110): alu_op = 3'b011;
            (funct3 == 3'b111): alu_op = 3'b010;
            default:            alu_bad = 1'b1;
        endcase
    end

    // Main decoder: control signals and immediate per opcode
    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        result_src = 2'b00;
        alu_ctrl   = 3'b000;
        illegal    = 1'b0;
        imm        = 32'd0;
        unique case (opcode)
            OP_LW: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                alu_src    = 1'b1;
                imm = {{20{instrD[31]}}, instrD[31:20]};
            end
            OP_SW: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
            end
            OP_R: begin
                reg_write = 1'b1;
                alu_ctrl  = alu_op;
                illegal   = alu_bad;
            end
            OP_I: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctrl  = alu_op;
                illegal   = alu_bad;
                imm = {{20{instrD[31]}}, instrD[31:20]};
            end
            OP_BEQ: begin
                branch   = 1'b1;
                alu_ctrl = 3'b001;
                imm = {{20{instrD[31]}}, instrD[7], instrD[30:25],
                       instrD[11:8], 1'b0};
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                result_src = 2'b10;
                jump       = 1'b1;
                imm = {{12{instrD[31]}}, instrD[19:12], instrD[20],
                       instrD[30:21], 1'b0};
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            jump       = 1'b0;
            branch     = 1'b0;
            alu_src    = 1'b0;
            result_src = 2'b00;
            alu_ctrl   = 3'b000;
        end
    end

    // Register reads; x0 is hardwired to zero
    always_comb begin
        rd1 = (rs1 == 5'd0) ? '0 : rf[rs1];
        rd2 = (rs2 == 5'd0) ? '0 : rf[rs2];
`ifdef DECODE_WB_BYPASS_EN
        if (RegWriteW && RdW != 5'd0 && RdW == rs1) rd1 = ResultW;
        if (RegWriteW && RdW != 5'd0 && RdW == rs2) rd2 = ResultW;
`endif
    end

    // Register file write-back; reset zeroes every entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
        end else if (RegWriteW && RdW != 5'd0) begin
            rf[RdW] <= ResultW;
        end
    end

    // D/E pipeline register; reset and flush both insert a bubble
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            RegWriteE   <= 1'b0;
            ResultSrcE  <= 2'b00;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ALUControlE <= 3'b000;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= 32'd0;
            RdE         <= 5'd0;
            Rs1E        <= 5'd0;
            Rs2E        <= 5'd0;
            PCE         <= 32'd0;
            PCplus4E    <= 32'd0;
            IllegalE    <= 1'b0;
        end else begin
            RegWriteE   <= reg_write;
            ResultSrcE  <= result_src;
            MemWriteE   <= mem_write;
            JumpE       <= jump;
            BranchE     <= branch;
            ALUSrcE     <= alu_src;
            ALUControlE <= alu_ctrl;
            RD1E        <= rd1;
            RD2E        <= rd2;
            ImmExtE     <= imm;
            RdE         <= rd;
            Rs1E        <= rs1;
            Rs2E        <= rs2;
            PCE         <= PCD;
            PCplus4E    <= PCplus4D;
            IllegalE    <= illegal;
        end
    end

endmodule

// File: doc/decode_mod.md
# decode_mod

Decode stage of the five-stage RISC-V pipeline. It takes the fetched instruction, PC and PC+1 from the fetch stage and decodes the RV32I subset into control signals. It holds the 32×32 register file, written back from W, and produces sign-extended immediates. All of this is registered into the D/E pipeline register feeding execute.

## Interface
Parameters:
- `REG_COUNT`, 32: register-file depth; must remain 32.
- `XLEN`, 32: data width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `FlushE` in 1: active-high; loads a bubble into the D/E register.
- `instrD` in 32: instruction from fetch.
- `PCD` in 32: word-addressed PC.
- `PCplus4D` in 32: next word address, PC+1.
- `RegWriteW` in 1: write-back enable.
- `RdW` in 5: write-back destination.
- `ResultW` in 32: write-back data.
- `RegWriteE` out 1: register-write enable.
- `ResultSrcE` out 2: result select: 00 ALU, 01 memory, 10 PC+1.
- `MemWriteE` out 1: data-memory write enable.
- `JumpE` out 1: jump indicator.
- `BranchE` out 1: branch indicator.
- `ALUSrcE` out 1: 1 = ImmExtE is ALU operand B.
- `ALUControlE` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `RD1E`, `RD2E` out 32: register read data.
- `ImmExtE` out 32: sign-extended byte-offset immediate.
- `RdE`, `Rs1E`, `Rs2E` out 5: register indices for the hazard unit.
- `PCE`, `PCplus4E` out 32: pipelined PC values.
- `IllegalE` out 1: unsupported opcode or funct was decoded.

## Operation
- Decoded opcodes:
  - 0000011 lw: RegWrite=1, ResultSrc=01, ALUSrc=1, I-imm, add.
  - 0100011 sw: MemWrite=1, ALUSrc=1, S-imm, add.
  - 0110011 R-type: RegWrite=1.
  - 0010011 I-ALU: RegWrite=1, ALUSrc=1, I-imm.
  - 1100011 beq: Branch=1, B-imm, sub.
  - 1101111 jal: RegWrite=1, ResultSrc=10, Jump=1, J-imm.
- ALU operation for R-type and I-ALU, selected by funct3:
  - 000: add. R-type with funct7[5]=1 selects sub; I-type always add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other funct3 is illegal.
- Immediates are sign-extended from instr[31]:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Scaling to word addresses is done in execute, not here.
- Illegal encodings, including instrD = 0x00000000:
  - All control outputs are 0 and IllegalE=1.
  - Data and index fields are still registered.
- Register file:
  - x0 reads 0 and ignores writes.
  - Write occurs on the rising edge when RegWriteW=1 and RdW≠0.
- Reset clears all 32 registers and all D/E outputs to 0.
- FlushE=1 clears all D/E outputs to 0; register-file writes still proceed.
- rst has priority over FlushE.

## Timing
- Latency: one cycle; inputs sampled at edge N appear on the E outputs after edge N.
- Register-file reads are combinational on instrD[19:15] and [24:20], captured at the edge.
- Write-back at edge N is visible to reads captured at edge N+1, or at edge N itself when the bypass is compiled in.
- Reset mid-stream: on the cycle after the rst edge, every output is 0 and the register file is zeroed. Operation resumes on the first edge with rst=0.
- There is no stall input; the hazard unit uses FlushE only.

## Configuration
- `DECODE_WB_BYPASS_EN`:
  - Defined: when RegWriteW=1, RdW≠0 and RdW equals rs1 or rs2, the corresponding RD is taken from ResultW in the same cycle (write-through).
  - Undefined: the read returns the pre-write register value, and the hazard unit must cover the W→D distance.

## Test plan
- Reset: hold rst=1 for 2 cycles with instrD=0x01AC89B3 → all outputs 0; then x25 and x26 read 0.
- R-type: write x25=7 and x26=5 via W, then instrD=0x01AC89B3 (add s3,s9,s10) → RegWriteE=1, ALUControlE=000, RD1E=7, RD2E=5, RdE=19, IllegalE=0.
- lw and sw:
  - instrD=0x02842903 (lw s2,40(s0)) → ResultSrcE=01, ALUSrcE=1, ImmExtE=40, RdE=18.
  - instrD=0x016EAA23 (sw s6,20(t4)) → MemWriteE=1, RegWriteE=0, ImmExtE=20, Rs2E=22.
- Sign extension and x0: instrD=0xFFF00293 (addi x5,x0,-1) → ImmExtE=0xFFFFFFFF, RD1E=0. Separately, a W write to x0 of 0x55 → x0 still reads 0.
- Bypass: in the same cycle, RegWriteW=1, RdW=25, ResultW=0xAA and instrD reads x25 → RD1E=0xAA with the macro defined, old value without it.
- Flush and illegal:
  - FlushE=1 during a valid add → next-cycle outputs all 0, while a concurrent W write still lands.
  - instrD=0x00000000 → IllegalE=1 with all control outputs 0.
